// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if: FIFO read-side and word-stream signals of the byte-to-word packer
interface fifo_word_packer_if #(parameter int BPW = 4) ();
  logic fifo_empty, fifo_wn, fifo_rn, flush, m_valid, m_ready;
  logic [7:0] fifo_dout;
  logic [8*BPW-1:0] m_data;
  logic [2:0] m_bytes;
  modport master (
    input fifo_empty, fifo_wn, fifo_dout, flush, m_ready,
    output fifo_rn, m_valid, m_data, m_bytes
  );
  modport slave (
    output fifo_empty, fifo_wn, fifo_dout, flush, m_ready,
    input fifo_rn, m_valid, m_data, m_bytes
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains the byte FIFO and packs bytes little-endian into BPW-byte stream words
module fifo_word_packer #(
  parameter int BPW = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  fifo_word_packer_if.master bus
);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nxt;
  logic [8*BPW-1:0] asm_r;
  logic [2:0] byte_cnt;
  logic rd_pend, flush_req, part, ev, load, full;
  logic [IW-1:0] idle_cnt;
  // a read is only issued when it is guaranteed to be accepted and to fit in the word
  assign bus.fifo_rn = !bus.fifo_empty && !bus.fifo_wn && state == FILL &&
                       ({1'b0, byte_cnt} + {3'b0, rd_pend}) < 4'(BPW);
  // flush event, output reload and next state
  always_comb begin
    part = byte_cnt != 3'd0 && !rd_pend;
    ev = state == FILL && part && (flush_req || bus.flush || idle_cnt == IW'(TIMEOUT));
    load = state == HOLD && (!bus.m_valid || bus.m_ready);
    full = byte_cnt + 3'(rd_pend) == 3'(BPW);
    state_nxt = load ? FILL : (state == FILL && (ev || full)) ? HOLD : state;
  end
  // state, byte capture, flush bookkeeping and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      asm_r <= '0;
      byte_cnt <= '0;
      rd_pend <= 1'b0;
      flush_req <= 1'b0;
      idle_cnt <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      bus.m_bytes <= '0;
    end else begin
      state <= state_nxt;
      rd_pend <= bus.fifo_rn;
      flush_req <= (flush_req || bus.flush) && !ev && !load && (byte_cnt != 3'd0 || rd_pend);
      idle_cnt <= (state == FILL && part && bus.fifo_empty && !ev) ? idle_cnt + 1'b1 : '0;
      if (load) begin
        asm_r <= '0;
        byte_cnt <= '0;
      end else if (rd_pend) begin
        for (int i = 0; i < BPW; i++)
          if (byte_cnt == 3'(i)) asm_r[8*i +: 8] <= bus.fifo_dout;
        byte_cnt <= byte_cnt + 3'd1;
      end
      bus.m_valid <= load || (bus.m_valid && !bus.m_ready);
      if (load) begin
        bus.m_data <= asm_r;
        bus.m_bytes <= byte_cnt;
      end
    end
  end
endmodule
